rom_c_read_d_server: RTL and testbench

Responder side of the C-table and read/D-table fetch interface. Holds the 4-entry C table (one 8-bit count per base A/C/G/T) and the per-position read-base / D table. Answers `ce_rom_C`/`addr_rom_C` and `ce_rom_read_and_D`/`addr_rom_read_and_D` requests from the data-fetch stage with registered data. Includes a streaming loader FSM that fills both tables from a host word stream before search starts.

---
 rtl/rom_c_read_d_server_pkg.sv | 32 +++
 rtl/rd_table_mem.sv | 31 +++
 rtl/rom_c_read_d_server.sv | 162 ++++++++++++++++
 tb/tb_rom_c_read_d_server.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_c_read_d_server_pkg.sv
// Shared types and constants for the C-table / read-D responder.
// ROM_PARITY_EN adds one even-parity bit to each stored read/D entry.
package rom_c_read_d_server_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_LOAD_C  = 2'b01,
    S_LOAD_RD = 2'b10,
    S_READY   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_C = 2'b01,
    BASE_G = 2'b10,
    BASE_T = 2'b11
  } base_e;

  localparam int unsigned C_W    = 8;
  localparam int unsigned D_W    = 8;
  localparam int unsigned RB_W   = 2;
  localparam int unsigned LOAD_W = RB_W + D_W;

`ifdef ROM_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif

  localparam int unsigned ENTRY_W = LOAD_W + PAR_W;

endpackage

// File: rtl/rd_table_mem.sv
// Synchronous 1W/1R read/D storage with registered read, shaped for RAM inference.
// Entry width includes the parity bit when ROM_PARITY_EN is defined.
module rd_table_mem #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = 10,
  parameter int unsigned AW    = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rom_c_read_d_server.sv
// C-table and read/D-table responder with a streaming table loader.
// ROM_PARITY_EN adds per-entry parity checking and the par_flip test hook.
module rom_c_read_d_server
  import rom_c_read_d_server_pkg::*;
#(
  parameter int unsigned READ_LEN = 256,
  parameter int unsigned AW       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [LOAD_W-1:0] load_data,
`ifdef ROM_PARITY_EN
  input  logic              par_flip,
`endif
  output logic              load_ready,
  output logic              tables_ready,
  input  logic              ce_rom_C,
  input  logic [1:0]        addr_rom_C,
  input  logic              ce_rom_read_and_D,
  input  logic [AW-1:0]     addr_rom_read_and_D,
  output logic [C_W-1:0]    data,
  output logic [D_W-1:0]    d_i,
  output logic [RB_W-1:0]   read_i,
  output logic              rd_err
);

  localparam logic [AW:0]   ReadLenW = (AW+1)'(READ_LEN);
  localparam logic [AW-1:0] LastRd   = AW'(READ_LEN - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic                c_we, rd_we;
  logic [C_W-1:0]      c_q [4];
  logic [C_W-1:0]      data_q;
  logic                rd_zero_q;
  logic                rng_err_q;
  logic                is_ready, in_range, rd_re;
  logic [ENTRY_W-1:0]  mem_wdata, mem_rdata;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    c_we         = 1'b0;
    rd_we        = 1'b0;
    load_ready   = (state_q == S_LOAD_C) || (state_q == S_LOAD_RD);
    tables_ready = (state_q == S_READY);
    // A start pulse restarts the load and drops any word offered with it.
    if (load_start) begin
      state_d = S_LOAD_C;
      cnt_d   = '0;
    end else if (load_valid && load_ready) begin
      case (state_q)
        S_LOAD_C: begin
          c_we = 1'b1;
          if (base_e'(cnt_q[1:0]) == BASE_T) begin
            cnt_d   = '0;
            state_d = S_LOAD_RD;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
        S_LOAD_RD: begin
          rd_we = 1'b1;
          if (cnt_q == LastRd) begin
            cnt_d   = '0;
            state_d = S_READY;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign is_ready = (state_q == S_READY);
  assign in_range = ({1'b0, addr_rom_read_and_D} < ReadLenW);
  assign rd_re    = ce_rom_read_and_D && is_ready && in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      rd_zero_q <= 1'b1;
      rng_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ce_rom_C) begin
        data_q <= is_ready ? c_q[addr_rom_C] : '0;
      end
      if (ce_rom_read_and_D) begin
        rd_zero_q <= !rd_re;
        rng_err_q <= is_ready && !in_range;
      end
    end
  end

  // Table contents survive reset; they are unreachable until the next load completes.
  always_ff @(posedge clk) begin
    if (c_we) begin
      c_q[cnt_q[1:0]] <= load_data[C_W-1:0];
    end
  end

`ifdef ROM_PARITY_EN
  logic par_chk_q;
  logic flip_pend_q, flip_pend_d;
  logic flip_now;

  assign flip_now  = par_flip || flip_pend_q;
  assign mem_wdata = {(^load_data) ^ flip_now, load_data};

  always_comb begin
    flip_pend_d = flip_pend_q;
    if (rd_we) begin
      flip_pend_d = 1'b0;
    end else if (par_flip) begin
      flip_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_chk_q   <= 1'b0;
      flip_pend_q <= 1'b0;
    end else begin
      flip_pend_q <= flip_pend_d;
      if (ce_rom_read_and_D) begin
        par_chk_q <= rd_re;
      end
    end
  end

  assign rd_err = rng_err_q || (par_chk_q && (^mem_rdata));
`else
  assign mem_wdata = load_data;
  assign rd_err    = rng_err_q;
`endif

  rd_table_mem #(
    .Depth (READ_LEN),
    .Width (ENTRY_W),
    .AW    (AW)
  ) u_rd_table_mem (
    .clk_i   (clk),
    .we_i    (rd_we),
    .waddr_i (cnt_q),
    .wdata_i (mem_wdata),
    .re_i    (rd_re),
    .raddr_i (addr_rom_read_and_D),
    .rdata_o (mem_rdata)
  );

  assign data   = data_q;
  assign d_i    = rd_zero_q ? '0 : mem_rdata[D_W-1:0];
  assign read_i = rd_zero_q ? '0 : mem_rdata[LOAD_W-1:D_W];

endmodule

// File: tb/tb_rom_c_read_d_server.sv
// Bench for rom_c_read_d_server: two instances (READ_LEN 256 and 200) share stimulus
// and are compared against an array-based table model. ROM_PARITY_EN enables parity steps.
module tb_rom_c_read_d_server;

  localparam int unsigned AW   = 8;
  localparam int unsigned LenA = 256;
  localparam int unsigned LenB = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, load_start, load_valid;
  logic [9:0] load_data;
  logic       ce_c, ce_rd;
  logic [1:0] addr_c;
  logic [7:0] addr_rd;
`ifdef ROM_PARITY_EN
  logic       par_flip;
`endif

  logic       lr_a, tr_a, err_a, lr_b, tr_b, err_b;
  logic [7:0] data_a, d_a, data_b, d_b;
  logic [1:0] r_a, r_b;

  rom_c_read_d_server #(.READ_LEN(LenA), .AW(AW)) dut_a (
    .clk                 (clk),
    .rst                 (rst),
    .load_start          (load_start),
    .load_valid          (load_valid),
    .load_data           (load_data),
`ifdef ROM_PARITY_EN
    .par_flip            (par_flip),
`endif
    .load_ready          (lr_a),
    .tables_ready        (tr_a),
    .ce_rom_C            (ce_c),
    .addr_rom_C          (addr_c),
    .ce_rom_read_and_D   (ce_rd),
    .addr_rom_read_and_D (addr_rd),
    .data                (data_a),
    .d_i                 (d_a),
    .read_i              (r_a),
    .rd_err              (err_a)
  );

  rom_c_read_d_server #(.READ_LEN(LenB), .AW(AW)) dut_b (
    .clk                 (clk),
    .rst                 (rst),
    .load_start          (load_start),
    .load_valid          (load_valid),
    .load_data           (load_data),
`ifdef ROM_PARITY_EN
    .par_flip            (par_flip),
`endif
    .load_ready          (lr_b),
    .tables_ready        (tr_b),
    .ce_rom_C            (ce_c),
    .addr_rom_C          (addr_c),
    .ce_rom_read_and_D   (ce_rd),
    .addr_rom_read_and_D (addr_rd),
    .data                (data_b),
    .d_i                 (d_b),
    .read_i              (r_b),
    .rd_err              (err_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: table contents, readiness, and the last response per instance.
  logic [7:0] c_m [4];
  logic [7:0] d_m [256];
  logic [1:0] r_m [256];
  bit         bad_m [256];
  bit         ready_m;
  logic [7:0] exp_data [2];
  logic [7:0] exp_d    [2];
  logic [1:0] exp_r    [2];
  logic       exp_err  [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "/data_a"}, data_a, exp_data[0]);
    check({tag, "/d_a"},    d_a,    exp_d[0]);
    check({tag, "/read_a"}, r_a,    exp_r[0]);
    check({tag, "/err_a"},  err_a,  exp_err[0]);
    check({tag, "/data_b"}, data_b, exp_data[1]);
    check({tag, "/d_b"},    d_b,    exp_d[1]);
    check({tag, "/read_b"}, r_b,    exp_r[1]);
    check({tag, "/err_b"},  err_b,  exp_err[1]);
  endtask

  function automatic void predict(input bit cc, input logic [1:0] ac, input bit cr,
                                  input logic [7:0] ar);
    for (int k = 0; k < 2; k++) begin
      int unsigned len;
      len = (k == 0) ? LenA : LenB;
      if (cc) exp_data[k] = ready_m ? c_m[ac] : 8'd0;
      if (cr) begin
        if (!ready_m) begin
          exp_d[k] = 8'd0; exp_r[k] = 2'd0; exp_err[k] = 1'b0;
        end else if (int'(ar) >= int'(len)) begin
          exp_d[k] = 8'd0; exp_r[k] = 2'd0; exp_err[k] = 1'b1;
        end else begin
          exp_d[k] = d_m[ar]; exp_r[k] = r_m[ar]; exp_err[k] = bad_m[ar];
        end
      end
    end
  endfunction

  task automatic req(input string tag, input bit cc, input logic [1:0] ac, input bit cr,
                     input logic [7:0] ar);
    ce_c = cc; addr_c = ac; ce_rd = cr; addr_rd = ar;
    predict(cc, ac, cr, ar);
    tick();
    ce_c = 1'b0; ce_rd = 1'b0;
    check_outs(tag);
  endtask

  task automatic feed(input logic [9:0] w);
    load_valid = 1'b1; load_data = w;
    tick();
    load_valid = 1'b0;
  endtask

  // Full load of 4 C words + 256 read/D words with random idle gaps.
  task automatic do_load(input bit rnd);
    logic [9:0] w;
    load_start = 1'b1; load_valid = 1'b1; load_data = 10'h3ff;
    tick();
    load_start = 1'b0; load_valid = 1'b0;
    ready_m = 1'b0;
    for (int i = 0; i < 256; i++) bad_m[i] = 1'b0;
    check("start/load_ready", lr_a, 1);
    check("start/tables_ready", tr_a, 0);
    for (int k = 0; k < 260; k++) begin
      while ($urandom_range(0, 3) == 0) tick();
      if (k < 4) begin
        w = rnd ? 10'($urandom) : {2'b00, 8'(10 * (k + 1))};
        c_m[k] = w[7:0];
      end else begin
        w = rnd ? 10'($urandom) : {2'((k - 4) % 4), 8'(k - 4)};
        d_m[k-4] = w[7:0];
        r_m[k-4] = w[9:8];
      end
`ifdef ROM_PARITY_EN
      par_flip = !rnd && (k == 13);
      if (!rnd && k == 13) bad_m[9] = 1'b1;
`endif
      feed(w);
`ifdef ROM_PARITY_EN
      par_flip = 1'b0;
`endif
      if (k == 202) check("b_not_ready_202", tr_b, 0);
      if (k == 203) check("b_ready_204", tr_b, 1);
      if (k == 203) check("a_not_ready_204", tr_a, 0);
      if (k == 258) check("a_not_ready_259", tr_a, 0);
      if (k == 259) check("a_ready_260", tr_a, 1);
      if (k == 259) check("a_load_ready_off", lr_a, 0);
    end
    ready_m = 1'b1;
  endtask

  task automatic random_reqs(input int n);
    for (int i = 0; i < n; i++) begin
      req("rand", 1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    ce_c = 1'b0; addr_c = '0; ce_rd = 1'b0; addr_rd = '0;
`ifdef ROM_PARITY_EN
    par_flip = 1'b0;
`endif
    ready_m = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_data[k] = '0; exp_d[k] = '0; exp_r[k] = '0; exp_err[k] = 1'b0;
    end
    tick();
    tick();
    check_outs("reset");
    check("reset/load_ready", lr_a, 0);
    check("reset/tables_ready", tr_a, 0);
    rst = 1'b0;
    tick();
    check("idle/load_ready", lr_a, 0);

    req("pre_load", 1'b1, 2'd1, 1'b1, 8'd5);
    check("pre_load/d_i", d_a, 0);
    check("pre_load/rd_err", err_a, 0);

    do_load(1'b0);

    req("c_addr2", 1'b1, 2'd2, 1'b0, 8'd0);
    check("c_addr2/const", data_a, 30);

    req("dual", 1'b1, 2'd3, 1'b1, 8'd7);
    check("dual/data", data_a, 40);
    check("dual/d_i", d_a, 7);
    check("dual/read_i", r_a, 3);
    check("dual/rd_err", err_a, 0);

    req("range250", 1'b0, 2'd0, 1'b1, 8'd250);
    check("range250/b_err", err_b, 1);
    check("range250/b_d", d_b, 0);
    check("range250/a_d", d_a, 250);

    for (int i = 0; i < 5; i++) begin
      addr_c = 2'($urandom); addr_rd = 8'($urandom);
      tick();
      check_outs("hold");
    end

`ifdef ROM_PARITY_EN
    req("par9", 1'b0, 2'd0, 1'b1, 8'd9);
    check("par9/d_i", d_a, 9);
    check("par9/rd_err", err_a, 1);
    req("par8", 1'b0, 2'd0, 1'b1, 8'd8);
    check("par8/rd_err", err_a, 0);
`endif

    random_reqs(60);

    // Reload started after 100 read/D words: the restart must land in LOAD_C.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    ready_m = 1'b0;
    check("reload/tables_ready", tr_a, 0);
    for (int k = 0; k < 104; k++) feed(10'($urandom));
    do_load(1'b1);
    random_reqs(60);

    // Reset in the middle of a load.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    ready_m = 1'b0;
    for (int k = 0; k < 50; k++) feed(10'($urandom));
    rst = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      exp_data[k] = '0; exp_d[k] = '0; exp_r[k] = '0; exp_err[k] = 1'b0;
    end
    check_outs("mid_rst");
    check("mid_rst/load_ready", lr_a, 0);
    check("mid_rst/tables_ready", tr_b, 0);
    rst = 1'b0;
    tick();
    check("post_rst/load_ready", lr_b, 0);
    req("post_rst_req", 1'b1, 2'd2, 1'b1, 8'd3);

    do_load(1'b1);
    random_reqs(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
